// File: rtl/y_deser_pkg.sv
// Shared types for the y_out deserializer: detector state encoding, collector FSM states, defaults.
package y_deser_pkg;

    localparam int unsigned Y_DESER_WIDTH_DEF = 8;
    localparam int unsigned Y_DESER_DEPTH_DEF = 4;

    typedef enum logic [2:0] {
        S0 = 3'b000,
        S1 = 3'b001,
        S2 = 3'b010,
        S3 = 3'b011,
        S4 = 3'b100
    } det_state_t;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } col_state_t;

endpackage

// File: rtl/y_deser_fifo.sv
// Small register FIFO with sync clear; head read combinationally from storage.
// Latency: push visible on the next cycle. A push while full is accepted only if a pop happens that edge.
module y_deser_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          clr,
    input  logic          push,
    input  logic [DW-1:0] push_dat,
    input  logic          pop,
    output logic [DW-1:0] head_dat,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] cnt;
    logic          wr_en;
    logic          rd_en;

    assign full     = (cnt == LW'(DEPTH));
    assign empty    = (cnt == '0);
    assign rd_en    = pop & ~empty;
    assign wr_en    = push & (~full | rd_en);
    assign head_dat = mem[rd_ptr];
    assign level    = cnt;

    // Storage is cleared too so the head reads zero whenever the FIFO is empty after reset/clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + LW'(wr_en) - LW'(rd_en);
        end
    end

endmodule

// File: rtl/y_deser.sv
// Packs WIDTH en-qualified y_in samples LSB-first into words queued in a valid/ready FIFO.
// Latency: m_valid one cycle after the final bit's edge. Full FIFO without a pop drops the word and sets sticky ovf.
// Optional Y_DESER_STATE_TRACE_EN stores the detector state sampled with each word's final bit.
module y_deser
    import y_deser_pkg::*;
#(
    parameter int WIDTH = Y_DESER_WIDTH_DEF,
    parameter int DEPTH = Y_DESER_DEPTH_DEF,
    localparam int LW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             en,
    input  logic             y_in,
`ifdef Y_DESER_STATE_TRACE_EN
    input  logic [2:0]       state_in,
    output logic [2:0]       m_state,
`endif
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [LW-1:0]    level,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);
`ifdef Y_DESER_STATE_TRACE_EN
    localparam int FW = WIDTH + 3;
`else
    localparam int FW = WIDTH;
`endif

    col_state_t        state;
    col_state_t        state_nxt;
    logic [CW-1:0]     cnt;
    logic [WIDTH-1:0]  sr;
    logic [WIDTH-1:0]  word;
    logic              sample;
    logic              last;
    logic              done;
    logic              full;
    logic              empty;
    logic              pop_fire;
    logic [FW-1:0]     push_dat;
    logic [FW-1:0]     head_dat;

    assign sample   = en & ~clr;
    assign last     = (state == FILL) && (cnt == CW'(WIDTH - 1));
    assign pop_fire = m_ready & ~empty;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)    state <= IDLE;
        else if (clr) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (sample) begin
            case (state)
                IDLE:    state_nxt = FILL;
                FILL:    if (last) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        done = sample & last;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
            sr  <= '0;
        end else if (clr) begin
            cnt <= '0;
            sr  <= '0;
        end else if (sample) begin
            if (done) begin
                cnt <= '0;
                sr  <= '0;
            end else begin
                cnt     <= cnt + 1'b1;
                sr[cnt] <= y_in;
            end
        end
    end

    // The final bit bypasses the shift register so the word is pushed on its own edge.
    always_comb begin
        word            = sr;
        word[WIDTH-1]   = y_in;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                         ovf <= 1'b0;
        else if (clr)                      ovf <= 1'b0;
        else if (done & full & ~pop_fire)  ovf <= 1'b1;
    end

`ifdef Y_DESER_STATE_TRACE_EN
    assign push_dat = {state_in, word};
    assign m_state  = head_dat[FW-1 -: 3];
`else
    assign push_dat = word;
`endif
    assign m_data  = head_dat[WIDTH-1:0];
    assign m_valid = ~empty;

    y_deser_fifo #(
        .DW    (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .clr      (clr),
        .push     (done),
        .push_dat (push_dat),
        .pop      (m_ready),
        .head_dat (head_dat),
        .full     (full),
        .empty    (empty),
        .level    (level)
    );

endmodule

// File: tb/tb_y_deser.sv
// Self-checking bench for y_deser (WIDTH=8, DEPTH=4): directed scenarios then random traffic vs a queue model.
module tb_y_deser;
    import y_deser_pkg::*;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       clr = 1'b0;
    logic       en = 1'b0;
    logic       y_in = 1'b0;
    logic       m_ready = 1'b0;
    logic [2:0] st = 3'b000;
    logic       m_valid;
    logic [7:0] m_data;
    logic [2:0] level;
    logic       ovf;
`ifdef Y_DESER_STATE_TRACE_EN
    logic [2:0] m_state;
`endif

    int n_chk = 0;
    int n_pass = 0;

    // Reference model: queue of completed words, partial bit collection, sticky flag.
    logic [7:0] q_dat [$];
    logic [2:0] q_st  [$];
    logic [7:0] part;
    int         nbits;
    logic       movf;

    always #5 clk = ~clk;

    y_deser #(.WIDTH(8), .DEPTH(4)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .clr      (clr),
        .en       (en),
        .y_in     (y_in),
`ifdef Y_DESER_STATE_TRACE_EN
        .state_in (st),
        .m_state  (m_state),
`endif
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .level    (level),
        .ovf      (ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        q_dat.delete();
        q_st.delete();
        part  = 8'h00;
        nbits = 0;
        movf  = 1'b0;
    endtask

    task automatic model_edge(input logic e, input logic y, input logic r, input logic c, input logic [2:0] s);
        int  pre;
        logic pop;
        if (c) begin
            model_reset();
            return;
        end
        pre = q_dat.size();
        pop = r && (pre > 0);
        if (pop) begin
            void'(q_dat.pop_front());
            void'(q_st.pop_front());
        end
        if (e) begin
            part[nbits] = y;
            nbits++;
            if (nbits == 8) begin
                if (pre == 4 && !pop) movf = 1'b1;
                else begin
                    q_dat.push_back(part);
                    q_st.push_back(s);
                end
                part  = 8'h00;
                nbits = 0;
            end
        end
    endtask

    task automatic compare_outputs();
        check("m_valid", 32'(m_valid), 32'(q_dat.size() > 0));
        check("level", 32'(level), 32'(q_dat.size()));
        check("ovf", 32'(ovf), 32'(movf));
        if (q_dat.size() > 0) begin
            check("m_data", 32'(m_data), 32'(q_dat[0]));
`ifdef Y_DESER_STATE_TRACE_EN
            check("m_state", 32'(m_state), 32'(q_st[0]));
`endif
        end
    endtask

    task automatic step(input logic e, input logic y, input logic r, input logic c, input logic [2:0] s);
        en = e; y_in = y; m_ready = r; clr = c; st = s;
        @(posedge clk);
        model_edge(e, y, r, c, s);
        #1;
        compare_outputs();
    endtask

    task automatic send_word(input logic [7:0] w, input logic r_last);
        for (int i = 0; i < 8; i++)
            step(1'b1, w[i], (i == 7) ? r_last : 1'b0, 1'b0, (i == 7) ? 3'(S4) : 3'(S1));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(m_valid), 32'd0);
        check({tag, "_level"}, 32'(level), 32'd0);
        check({tag, "_ovf"}, 32'(ovf), 32'd0);
        check({tag, "_data"}, 32'(m_data), 32'd0);
`ifdef Y_DESER_STATE_TRACE_EN
        check({tag, "_state"}, 32'(m_state), 32'd0);
`endif
    endtask

    task automatic do_reset();
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        check_reset_outputs("rst");
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        logic [7:0] w;
        model_reset();
        #3;
        check_reset_outputs("por");
        @(negedge clk);
        rstn = 1'b1;

        // Basic word: 1,0,1,1,0,0,1,0 -> 8'h4D
        w = 8'h4D;
        for (int i = 0; i < 8; i++) step(1'b1, w[i], 1'b0, 1'b0, 3'(S2));
        check("basic_data", 32'(m_data), 32'h4D);
        check("basic_level", 32'(level), 32'd1);

        // Sample gating: 3 idle cycles after the 4th bit
        step(1'b0, 1'b0, 1'b1, 1'b0, 3'(S0));
        for (int i = 0; i < 4; i++) step(1'b1, w[i], 1'b0, 1'b0, 3'(S1));
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 3'(S1));
        for (int i = 4; i < 7; i++) step(1'b1, w[i], 1'b0, 1'b0, 3'(S1));
        check("gate_not_yet", 32'(m_valid), 32'd0);
        step(1'b1, w[7], 1'b0, 1'b0, 3'(S4));
        check("gate_data", 32'(m_data), 32'h4D);

        // Overflow: five words into a 4-deep FIFO, then drain
        step(1'b0, 1'b0, 1'b1, 1'b0, 3'(S0));
        for (int k = 1; k <= 5; k++) send_word(8'(k), 1'b0);
        check("ovf_level", 32'(level), 32'd4);
        check("ovf_flag", 32'(ovf), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            check("ovf_pop_order", 32'(m_data), 32'(k));
            step(1'b0, 1'b0, 1'b1, 1'b0, 3'(S0));
        end
        check("ovf_sticky", 32'(ovf), 32'd1);
        check("ovf_empty", 32'(m_valid), 32'd0);

        // Full plus pop on the completing edge
        step(1'b0, 1'b0, 1'b0, 1'b1, 3'(S0));
        for (int k = 1; k <= 4; k++) send_word(8'h10 + 8'(k), 1'b0);
        send_word(8'hA5, 1'b1);
        check("fpp_ovf", 32'(ovf), 32'd0);
        check("fpp_level", 32'(level), 32'd4);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b1, 1'b0, 3'(S0));
        check("fpp_drained", 32'(level), 32'd0);

        // Clear mid-word, then 1,1,1,1,0,0,0,0 -> 8'h0F
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 3'(S3));
        step(1'b1, 1'b1, 1'b0, 1'b1, 3'(S3));
        send_word(8'h0F, 1'b0);
        check("clr_data", 32'(m_data), 32'h0F);
        check("clr_level", 32'(level), 32'd1);
        check("clr_ovf", 32'(ovf), 32'd0);
`ifdef Y_DESER_STATE_TRACE_EN
        check("trace_state", 32'(m_state), 32'(S4));
`endif

        // Async reset after 5 bits of a new word
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 3'(S1));
        do_reset();
        send_word(8'h3C, 1'b0);
        check("post_rst_data", 32'(m_data), 32'h3C);

        // Random traffic
        for (int n = 0; n < 1500; n++)
            step(($urandom_range(3) != 0), 1'($urandom), 1'($urandom),
                 ($urandom_range(99) < 2), 3'($urandom_range(4)));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
